// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width and result record
package alu_pkg;

  localparam int ALU_WIDTH = 18;

  typedef struct packed {
    logic                 ovf;
    logic                 zero;
    logic [ALU_WIDTH-1:0] data;
  } alu_result_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // clear wins over a same-cycle increment; the count holds at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != {W{1'b1}}))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - ALU result capture FIFO with drop and flag statistics
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_ovf,
  input  logic                     in_zero,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_ovf,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         ovf_count,
  output logic [CNT_W-1:0]         zero_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     sticky_ovf,
  input  logic                     clear_stats
);

  localparam int AW = $clog2(DEPTH);

  // entry layout matches alu_result_t: {ovf, zero, data}
  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [WIDTH+1:0] head;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;
  assign drop      = in_valid && full;
  assign count     = wr_ptr - rd_ptr;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign out_ovf  = head[WIDTH+1];
  assign out_zero = head[WIDTH];
  assign out_data = head[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {in_ovf, in_zero, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // a new overflow must not be lost to a concurrent clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_ovf <= 1'b0;
    else if (push && in_ovf)
      sticky_ovf <= 1'b1;
    else if (clear_stats)
      sticky_ovf <= 1'b0;
  end

  sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_stats),
    .inc   (push && in_ovf),
    .q     (ovf_count)
  );

  sat_counter #(.W(CNT_W)) u_zero_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_stats),
    .inc   (push && in_zero),
    .q     (zero_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_stats),
    .inc   (drop),
    .q     (drop_count)
  );

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - directed self-checking bench for alu_result_fifo
module tb_alu_result_fifo;

  localparam int WIDTH = 18;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ovf;
  logic             in_zero;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_zero;
  logic [3:0]       count;
  logic [CNT_W-1:0] ovf_count;
  logic [CNT_W-1:0] zero_count;
  logic [CNT_W-1:0] drop_count;
  logic             sticky_ovf;
  logic             clear_stats;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ovf      (in_ovf),
    .in_zero     (in_zero),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_zero    (out_zero),
    .count       (count),
    .ovf_count   (ovf_count),
    .zero_count  (zero_count),
    .drop_count  (drop_count),
    .sticky_ovf  (sticky_ovf),
    .clear_stats (clear_stats)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; in_zero = 1'b0;
    out_ready = 1'b0; clear_stats = 1'b0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stats", {ovf_count, zero_count, drop_count, sticky_ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // three pushes, last one flagged zero, then drain in order
    in_valid = 1'b1;
    in_data = 14; tick();
    in_data = 16; tick();
    in_data = 0; in_zero = 1'b1; tick();
    in_valid = 1'b0; in_zero = 1'b0;
    chk("t1_count", count, 3);
    chk("t1_zero_count", zero_count, 1);
    out_ready = 1'b1;
    chk("t1_pop0", out_data, 14); tick();
    chk("t1_pop1", out_data, 16); tick();
    chk("t1_pop2", {out_zero, out_data}, {1'b1, 18'd0}); tick();
    chk("t1_empty", out_valid, 0);
    out_ready = 1'b0;

    // overfill: 10 pushes into 8 entries
    clear_pulse();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(100 + i);
      tick();
      if (i == 6) chk("t2_ready_at7", in_ready, 1);
      if (i == 7) chk("t2_ready_at8", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("t2_count", count, 8);
    chk("t2_drops", drop_count, 2);
    chk("t2_head", out_data, 100);

    // full with push and pop together: pop happens, push is dropped
    in_valid = 1'b1; in_data = 200; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3_count", count, 7);
    chk("t3_drops", drop_count, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("t3_drain", out_data, 32'(101 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty", out_valid, 0);

    // streaming across pointer wrap-around
    clear_pulse();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = WIDTH'(i);
      if (i > 0) begin
        chk("t4_data", {out_valid, out_data}, {1'b1, 18'(i - 1)});
        chk("t4_count", count, 1);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("t4_last", out_data, 39);
    tick();
    out_ready = 1'b0;
    chk("t4_empty", out_valid, 0);
    chk("t4_drops", drop_count, 0);

    // overflow stats, clear, and set-versus-clear in one cycle
    clear_pulse();
    in_valid = 1'b1; in_ovf = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = WIDTH'(i);
      tick();
    end
    in_valid = 1'b0; in_ovf = 1'b0;
    chk("t5_ovf_count", ovf_count, 3);
    chk("t5_sticky", sticky_ovf, 1);
    clear_pulse();
    chk("t5_clr_ovf", ovf_count, 0);
    chk("t5_clr_sticky", sticky_ovf, 0);
    chk("t5_clr_count", count, 3);
    chk("t5_clr_head", {out_ovf, out_data}, {1'b1, 18'd1});
    in_valid = 1'b1; in_ovf = 1'b1; in_data = 4; clear_stats = 1'b1;
    tick();
    in_valid = 1'b0; in_ovf = 1'b0; clear_stats = 1'b0;
    chk("t5_race_ovf", ovf_count, 0);
    chk("t5_race_sticky", sticky_ovf, 1);
    chk("t5_race_count", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t5_drain", out_data, 32'(i));
      tick();
    end
    out_ready = 1'b0;

    // saturation at 15 with a 4-bit counter
    clear_pulse();
    out_ready = 1'b1; in_valid = 1'b1; in_ovf = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = WIDTH'(500 + i);
      tick();
    end
    out_ready = 1'b0; in_ovf = 1'b0;
    chk("t6_ovf_sat", ovf_count, 15);
    chk("t6_count", count, 1);
    for (int i = 0; i < 10; i++) begin
      in_data = WIDTH'(600 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_full", count, 8);
    chk("t6_drops", drop_count, 3);

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_count", count, 0);
    chk("t6_arst_valid", out_valid, 0);
    chk("t6_arst_ready", in_ready, 1);
    chk("t6_arst_stats", {ovf_count, zero_count, drop_count, sticky_ovf}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream capture stage for the 18-bit ALU: each cycle the producer asserts `in_valid`, the block stores the result word together with its `ovf` and `isZero` flags in a DEPTH-entry FIFO and presents them to the consumer through a valid/ready handshake. The ALU cannot stall, so results that arrive while the FIFO is full are dropped and counted. The block also keeps saturating statistics (overflows, zeros, drops) and a sticky overflow flag for the control/debug logic.

## Interface
- `WIDTH`, 18, result data width (matches ALU_out)
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `CNT_W`, 16, width of each statistics counter
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  ALU result present this cycle
- `in_data`  in  WIDTH  ALU result
- `in_ovf`  in  1  ALU overflow flag for `in_data`
- `in_zero`  in  1  ALU zero flag for `in_data`
- `in_ready`  out  1  FIFO can accept (= not full)
- `out_valid`  out  1  head entry valid (= not empty)
- `out_ready`  in  1  consumer takes head this cycle
- `out_data`  out  WIDTH  head data
- `out_ovf`  out  1  head overflow flag
- `out_zero`  out  1  head zero flag
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `ovf_count`  out  CNT_W  accepted entries with ovf=1, saturating
- `zero_count`  out  CNT_W  accepted entries with zero=1, saturating
- `drop_count`  out  CNT_W  results lost to full FIFO, saturating
- `sticky_ovf`  out  1  set by any accepted ovf entry
- `clear_stats`  in  1  sync pulse: zero the three counters and `sticky_ovf`

## Operation
- Push when `in_valid && in_ready`: write {ovf, zero, data} at wr_ptr, wr_ptr+1 mod DEPTH.
- Pop when `out_valid && out_ready`: rd_ptr+1 mod DEPTH.
- Drop when `in_valid && !in_ready`: data discarded, `drop_count`+1.
- Pointers are $clog2(DEPTH)+1 bits; full when the index bits are equal and the MSBs differ; empty when the pointers are equal. `count` = wr_ptr − rd_ptr.
- Push and pop together when not full and not empty: `count` unchanged, both pointers advance.
- Push and pop together when full: no push (`in_ready` = 0), so the entry is dropped; the pop still occurs.
- Pop when empty: no effect (`out_valid` = 0).
- Counters saturate at 2^CNT_W−1 and never wrap.
- `clear_stats` takes priority over an increment in the same cycle: the counters read 0 afterwards and the concurrent event is not counted. It does not affect FIFO contents.
- `sticky_ovf` sets on an accepted entry with ovf=1; it clears only on `clear_stats` or reset. Set wins over `clear_stats` in the same cycle.
- Dropped entries do not touch `ovf_count`, `zero_count` or `sticky_ovf`.

## Timing
- Reset values: pointers 0, `count` 0, `out_valid` 0, `in_ready` 1, all counters 0, `sticky_ovf` 0.
- `out_data`, `out_ovf` and `out_zero` are a combinational read of mem[rd_ptr]; their value is don't-care while `out_valid` = 0.
- Memory contents are not reset.
- Latency: a push at edge N gives `out_valid` = 1 with that data after edge N (first-word fall-through, 1 cycle).
- `in_ready` and `out_valid` are derived from registered pointers only. There is no combinational path from `out_ready` to `in_ready`.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous). Entries in flight are lost, and the loss is not counted as drops.
- Statistics outputs update one edge after the event.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_WIDTH` = 18.
  - Typedef `alu_result_t` {ovf, zero, data[ALU_WIDTH-1:0]}, also used by the ALU and the upstream operand sequencer.
- Sub-module `sat_counter` (params W; ports clk, rst_n, clr, inc, q) is instantiated three times for the ovf, zero and drop counts.
- The FIFO storage is an internal register array, not a separate module.

## Test plan
- Reset, then push 14, 16, 0 (zero=1) with `out_ready` = 0 → `count` = 3, `zero_count` = 1; then pop with `out_ready` = 1 → outputs 14, 16, 0 in order, then `out_valid` = 0.
- Push 10 entries back-to-back with DEPTH = 8 and `out_ready` = 0 → `in_ready` drops after 8, `count` = 8, `drop_count` = 2; the head is still the first value.
- Full FIFO, `in_valid` and `out_ready` both high for 1 cycle → one pop, one drop, `count` = 7.
- Continuous push and pop of a counter sequence for 40 cycles → data in order across pointer wrap-around, `count` constant at 1 after the first cycle, no drops.
- Push 3 entries with ovf = 1 → `ovf_count` = 3, `sticky_ovf` = 1; `clear_stats` pulse → counters 0, `sticky_ovf` 0, FIFO contents intact.
- Force `ovf_count` near saturation with CNT_W = 4: 20 ovf pushes → holds at 15. Assert `rst_n` = 0 mid-stream → all outputs reach reset values without a clock edge.
